// File: rtl/mult_div_unit.sv
// Sequential multiply/divide unit feeding the HI/LO registers.
// A single shift engine runs either shift-add multiply or restoring divide over WIDTH iterations.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} stateT;

    stateT              state;
    logic               isDiv;
    logic               negLo;
    logic               negHi;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   operand;
    logic [2*WIDTH-1:0] acc;

    logic               startSigned;
    logic               startDiv;
    logic [WIDTH-1:0]   magA;
    logic [WIDTH-1:0]   magB;
    logic [WIDTH-1:0]   mulAddend;
    logic [WIDTH:0]     mulSum;
    logic [WIDTH:0]     divShift;
    logic               divFits;
    logic [WIDTH-1:0]   divTrial;
    logic [WIDTH-1:0]   divRem;
    logic [2*WIDTH-1:0] fixProd;

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide;
    // operand holds the multiplicand or divisor magnitude.
    always_comb begin
        startSigned = ~op[0];
        startDiv    = op[1];
        magA        = (startSigned && a[WIDTH-1]) ? -a : a;
        magB        = (startSigned && b[WIDTH-1]) ? -b : b;
        mulAddend   = acc[0] ? operand : '0;
        mulSum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mulAddend};
        divShift    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divFits     = divShift >= {1'b0, operand};
        divTrial    = divShift[WIDTH-1:0] - operand;
        divRem      = divFits ? divTrial : divShift[WIDTH-1:0];
        fixProd     = negLo ? -acc : acc;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            isDiv    <= 1'b0;
            negLo    <= 1'b0;
            negHi    <= 1'b0;
            count    <= '0;
            operand  <= '0;
            acc      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        isDiv <= startDiv;
                        negLo <= startSigned & (a[WIDTH-1] ^ b[WIDTH-1]);
                        negHi <= startSigned & a[WIDTH-1];
                        count <= '0;
                        busy  <= 1'b1;
                        if (startDiv) begin
                            operand <= magB;
                            acc     <= {{WIDTH{1'b0}}, magA};
                        end else begin
                            operand <= magA;
                            acc     <= {{WIDTH{1'b0}}, magB};
                        end
                        // A zero divisor skips the engine entirely and leaves hi/lo untouched.
                        if (startDiv && b == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (isDiv) begin
                        acc <= {divRem, acc[WIDTH-2:0], divFits};
                    end else begin
                        acc <= {mulSum, acc[WIDTH-1:1]};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (isDiv) begin
                        hi <= negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                        lo <= negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    end else begin
                        {hi, lo} <= fixProd;
                    end
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
